lsu_dmem_master: RTL and testbench

- Load/store unit that initiates every access to the word-addressed data memory on behalf of the datapath's MEM stage.
- Accepts one RISC-V load/store per handshake and computes the effective address.
- Checks alignment, range and funct3.
- Issues a word-wide read or byte-masked write to the memory array.
- For loads, waits the fixed memory read latency, then extracts and sign/zero-extends the addressed byte, half or word.
- Returns one response pulse per request.

---
 rtl/lsu_dmem_master.sv | 171 +++++++++++++++++
 tb/tb_lsu_dmem_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: RV32I load/store unit that drives a word-addressed data memory.
// All outputs are registered. Loads wait MEM_LATENCY cycles, then extract and extend a lane.
module lsu_dmem_master #(
    parameter int ADDR_WIDTH  = 5,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_base,
    input  logic [11:0]           req_imm,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_n;
    logic [31:0]     ea;
    logic [1:0]      off;
    logic            bad_f3;
    logic            misal;
    logic            oor;
    logic            err;
    logic [3:0]      be_n;
    logic [31:0]     wd_n;
    logic            op_store;
    logic [2:0]      op_f3;
    logic [1:0]      op_off;
    logic [CW-1:0]   cnt;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     ld_data;

    assign ea  = req_base + {{20{req_imm[11]}}, req_imm};
    assign off = ea[1:0];
    assign oor = |(ea >> (ADDR_WIDTH + 2));

    always_comb begin
        bad_f3 = 1'b0;
        if (req_store)
            bad_f3 = req_funct3 > 3'd2;
        else
            bad_f3 = (req_funct3 == 3'd3) | (req_funct3[2:1] == 2'b11);
    end

    assign misal = ((req_funct3[1:0] == 2'd1) & off[0])
                 | ((req_funct3[1:0] == 2'd2) & (|off));
    assign err   = bad_f3 | misal | oor;

    // Write data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be_n = 4'b1111;
        wd_n = req_wdata;
        if (req_store) begin
            unique case (1'b1)
                req_funct3[1:0] == 2'd0: begin
                    be_n = 4'b0001 << off;
                    wd_n = {4{req_wdata[7:0]}};
                end
                req_funct3[1:0] == 2'd1: begin
                    be_n = 4'b0011 << off;
                    wd_n = {2{req_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign lane_b = 8'(mem_rdata >> {op_off, 3'b000});
    assign lane_h = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_data = '0;
        unique case (1'b1)
            op_f3 == 3'd0: ld_data = {{24{lane_b[7]}}, lane_b};
            op_f3 == 3'd1: ld_data = {{16{lane_h[15]}}, lane_h};
            op_f3 == 3'd2: ld_data = mem_rdata;
            op_f3 == 3'd4: ld_data = {24'b0, lane_b};
            op_f3 == 3'd5: ld_data = {16'b0, lane_h};
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (req_valid) state_n = err ? RESP : ISSUE;
            ISSUE:   state_n = op_store ? RESP : WAIT;
            WAIT:    if (cnt == CW'(1)) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            op_store   <= 1'b0;
            op_f3      <= '0;
            op_off     <= '0;
            cnt        <= '0;
        end else begin
            req_ready  <= state_n == IDLE;
            resp_valid <= state_n == RESP;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid && err) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else if (req_valid) begin
                        op_store  <= req_store;
                        op_f3     <= req_funct3;
                        op_off    <= off;
                        mem_addr  <= ea[ADDR_WIDTH+1:2];
                        mem_be    <= be_n;
                        mem_wdata <= wd_n;
                        mem_we    <= req_store;
                        mem_re    <= !req_store;
                    end
                end
                ISSUE: begin
                    cnt <= CW'(MEM_LATENCY);
                    if (op_store) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        resp_rdata <= ld_data;
                        resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: directed vectors for two LSU instances (read latency 1 and 3),
// each attached to a small behavioural data memory.
module tb_lsu_dmem_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rv1, rv3;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [11:0] imm;
    logic [31:0] wd;

    logic        rdy1, rvl1, er1, mre1, mwe1;
    logic [31:0] rd1, mwd1, mrd1;
    logic [4:0]  ma1;
    logic [3:0]  mbe1;
    logic        rdy3, rvl3, er3, mre3, mwe3;
    logic [31:0] rd3, mwd3, mrd3;
    logic [4:0]  ma3;
    logic [3:0]  mbe3;

    lsu_dmem_master #(.ADDR_WIDTH(5), .MEM_LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv1), .req_ready(rdy1),
        .req_store(st), .req_funct3(f3),
        .req_base(base), .req_imm(imm), .req_wdata(wd),
        .resp_valid(rvl1), .resp_rdata(rd1), .resp_err(er1),
        .mem_addr(ma1), .mem_re(mre1), .mem_we(mwe1),
        .mem_be(mbe1), .mem_wdata(mwd1), .mem_rdata(mrd1)
    );

    lsu_dmem_master #(.ADDR_WIDTH(5), .MEM_LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv3), .req_ready(rdy3),
        .req_store(st), .req_funct3(f3),
        .req_base(base), .req_imm(imm), .req_wdata(wd),
        .resp_valid(rvl3), .resp_rdata(rd3), .resp_err(er3),
        .mem_addr(ma3), .mem_re(mre3), .mem_we(mwe3),
        .mem_be(mbe3), .mem_wdata(mwd3), .mem_rdata(mrd3)
    );

    logic [31:0] mem1 [32];
    logic [31:0] mem3 [32];
    logic [31:0] p0, p1;

    always @(posedge clk) begin
        if (mwe1)
            for (int i = 0; i < 4; i++)
                if (mbe1[i]) mem1[ma1][8*i +: 8] <= mwd1[8*i +: 8];
        if (mre1) mrd1 <= mem1[ma1];
    end

    always @(posedge clk) begin
        if (mwe3)
            for (int j = 0; j < 4; j++)
                if (mbe3[j]) mem3[ma3][8*j +: 8] <= mwd3[8*j +: 8];
        if (mre3) p0 <= mem3[ma3];
        p1   <= p0;
        mrd3 <= p1;
    end

    logic        sel;
    logic        rdy, rvl, er, mre, mwe;
    logic [31:0] rd, mwd;
    logic [4:0]  ma;
    logic [3:0]  mbe;

    assign rdy = sel ? rdy3 : rdy1;
    assign rvl = sel ? rvl3 : rvl1;
    assign er  = sel ? er3  : er1;
    assign mre = sel ? mre3 : mre1;
    assign mwe = sel ? mwe3 : mwe1;
    assign rd  = sel ? rd3  : rd1;
    assign mwd = sel ? mwd3 : mwd1;
    assign ma  = sel ? ma3  : ma1;
    assign mbe = sel ? mbe3 : mbe1;

    int          nvec = 0;
    int          nbad = 0;
    int          lat;
    int          extra;
    logic        s_re, s_we, any_re, any_we;
    logic        rdy_at, pulse_at, poke_rdy, r_err;
    logic [4:0]  s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd, r_data;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; lat = cycles from accept edge to the resp_valid cycle (0 = none).
    task automatic run(input bit s, input bit stv, input logic [2:0] f,
                       input logic [31:0] b, input logic [11:0] im,
                       input logic [31:0] w, input bit poke);
        int k;
        sel = s;
        @(posedge clk);
        @(negedge clk);
        rdy_at   = rdy;
        pulse_at = rvl;
        st = stv; f3 = f; base = b; imm = im; wd = w;
        if (s) rv3 = 1'b1; else rv1 = 1'b1;
        @(posedge clk); #1;
        rv1 = 1'b0; rv3 = 1'b0;
        lat = 0; any_re = 1'b0; any_we = 1'b0; poke_rdy = 1'b0;
        r_data = 'x; r_err = 1'bx;
        k = 0;
        while (lat == 0 && k < 12) begin
            k++;
            if (k == 1) begin
                s_re = mre; s_we = mwe; s_addr = ma; s_be = mbe; s_wd = mwd;
            end
            any_re = any_re | mre;
            any_we = any_we | mwe;
            if (rvl) begin
                lat = k; r_data = rd; r_err = er;
            end else begin
                if (poke && k == 2) begin
                    if (s) rv3 = 1'b1; else rv1 = 1'b1;
                    poke_rdy = rdy;
                end
                @(posedge clk); #1;
                rv1 = 1'b0; rv3 = 1'b0;
            end
        end
    endtask

    task automatic chk_err(input string tag);
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_err"}, r_err, 1);
        chk({tag, "_rdata"}, r_data, 0);
        chk({tag, "_re"}, any_re, 0);
        chk({tag, "_we"}, any_we, 0);
    endtask

    initial begin
        rst_n = 1'b0; rv1 = 1'b0; rv3 = 1'b0; sel = 1'b0;
        st = 1'b0; f3 = '0; base = '0; imm = '0; wd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy1, 1);
        chk("rst_valid", rvl1, 0);
        chk("rst_re", mre1, 0);
        chk("rst_we", mwe1, 0);
        chk("rst_rdata", rd1, 0);
        chk("rst_addr", ma1, 0);
        chk("rst_be", mbe1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 1, 3'd2, 32'h10, 12'h004, 32'hDEADBEEF, 0);
        chk("sw_ready", rdy_at, 1);
        chk("sw_lat", lat, 2);
        chk("sw_we", s_we, 1);
        chk("sw_re", any_re, 0);
        chk("sw_addr", s_addr, 5);
        chk("sw_be", s_be, 4'hF);
        chk("sw_wd", s_wd, 32'hDEADBEEF);
        chk("sw_err", r_err, 0);
        chk("sw_rdata", r_data, 0);

        run(0, 0, 3'd2, 32'h10, 12'h004, 32'h0, 0);
        chk("lw_pulse", pulse_at, 0);
        chk("lw_lat", lat, 3);
        chk("lw_re", s_re, 1);
        chk("lw_we", any_we, 0);
        chk("lw_addr", s_addr, 5);
        chk("lw_be", s_be, 4'hF);
        chk("lw_rdata", r_data, 32'hDEADBEEF);
        chk("lw_err", r_err, 0);

        run(0, 1, 3'd2, 32'h0, 12'h00C, 32'h80FF7F01, 0);
        chk("sw2_lat", lat, 2);
        run(0, 0, 3'd0, 32'hC, 12'h003, 32'h0, 0);
        chk("lb3", r_data, 32'hFFFFFF80);
        run(0, 0, 3'd4, 32'hC, 12'h003, 32'h0, 0);
        chk("lbu3", r_data, 32'h00000080);
        run(0, 0, 3'd0, 32'hC, 12'h001, 32'h0, 0);
        chk("lb1", r_data, 32'h0000007F);
        run(0, 0, 3'd1, 32'hC, 12'h002, 32'h0, 0);
        chk("lh2", r_data, 32'hFFFF80FF);
        run(0, 0, 3'd5, 32'hC, 12'h000, 32'h0, 0);
        chk("lhu0", r_data, 32'h00007F01);

        run(0, 1, 3'd0, 32'hC, 12'h002, 32'h000000AB, 0);
        chk("sb_be", s_be, 4'b0100);
        chk("sb_wd", s_wd, 32'hABABABAB);
        chk("sb_addr", s_addr, 3);
        run(0, 1, 3'd1, 32'hC, 12'h002, 32'h00001234, 0);
        chk("sh_be", s_be, 4'b1100);
        chk("sh_wd", s_wd, 32'h12341234);
        run(0, 0, 3'd2, 32'hC, 12'h000, 32'h0, 0);
        chk("lw_merge", r_data, 32'h12347F01);

        run(0, 0, 3'd2, 32'h6, 12'h000, 32'h0, 0);
        chk_err("e_lw_mis");
        run(0, 1, 3'd1, 32'h3, 12'h000, 32'h5555, 0);
        chk_err("e_sh_mis");
        run(0, 0, 3'd3, 32'h0, 12'h000, 32'h0, 0);
        chk_err("e_ld_f3");
        run(0, 1, 3'd3, 32'h0, 12'h000, 32'h0, 0);
        chk_err("e_st_f3");
        run(0, 0, 3'd2, 32'h80, 12'h000, 32'h0, 0);
        chk_err("e_range");
        run(0, 0, 3'd2, 32'h4, 12'hFF8, 32'h0, 0);
        chk_err("e_negwrap");

        run(0, 0, 3'd2, 32'hFFFFFFF4, 12'h020, 32'h0, 0);
        chk("wrap_lat", lat, 3);
        chk("wrap_addr", s_addr, 5);
        chk("wrap_rdata", r_data, 32'hDEADBEEF);

        run(1, 1, 3'd2, 32'h20, 12'hFFC, 32'hCAFEF00D, 0);
        chk("l3_sw_lat", lat, 2);
        chk("l3_sw_addr", s_addr, 7);
        run(1, 0, 3'd2, 32'h20, 12'hFFC, 32'h0, 1);
        chk("l3_lw_lat", lat, 5);
        chk("l3_lw_addr", s_addr, 7);
        chk("l3_lw_re", s_re, 1);
        chk("l3_lw_rdata", r_data, 32'hCAFEF00D);
        chk("l3_busy_ready", poke_rdy, 0);
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rvl3) extra++;
        end
        chk("l3_no_extra", extra, 0);

        @(negedge clk);
        st = 1'b0; f3 = 3'd2; base = 32'h1C; imm = '0; rv3 = 1'b1;
        @(posedge clk); #1;
        rv3 = 1'b0;
        chk("rw_issue_re", mre3, 1);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rw_ready", rdy3, 1);
        chk("rw_valid", rvl3, 0);
        chk("rw_re", mre3, 0);
        chk("rw_we", mwe3, 0);
        chk("rw_rdata", rd3, 0);
        chk("rw_err", er3, 0);
        chk("rw_addr", ma3, 0);
        chk("rw_be", mbe3, 0);
        chk("rw_wd", mwd3, 0);
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rvl3) extra++;
        end
        chk("rw_no_resp", extra, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
